// File: rtl/terminal_input_pkg.sv
// rtl/terminal_input_pkg.sv - shared peripheral constants for the terminal input port
package terminal_input_pkg;

    localparam logic [23:0] TERMIN_BASE  = 24'h000001;

    localparam logic [3:0]  OFFS_DATA    = 4'h0;
    localparam logic [3:0]  OFFS_STATUS  = 4'h4;
    localparam logic [3:0]  OFFS_CONTROL = 4'h8;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_IRQ_EN    = 3;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;
    localparam int CTRL_IRQ_EN  = 2;

    // Also returned by the terminal output port when it has nothing to report.
    localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;

endpackage

// File: rtl/terminal_input_if.sv
// rtl/terminal_input_if.sv - CPU data bus and key stream signals of the terminal input port
interface terminal_input_if;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic [7:0]  key_data;
    logic        key_valid;
    logic        key_ready;
    logic        irq;

    modport master (
        output we, re, addr, data_write, key_data, key_valid,
        input  data_read, key_ready, irq
    );

    modport slave (
        input  we, re, addr, data_write, key_data, key_valid,
        output data_read, key_ready, irq
    );
endinterface

// File: rtl/terminal_input_byte_fifo.sv
// rtl/terminal_input_byte_fifo.sv - byte FIFO with flush; push/pop are ignored when full/empty
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    // Storage is left uninitialised; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/terminal_input.sv
// rtl/terminal_input.sv - memory-mapped terminal input: key stream into a FIFO drained by CPU loads
module terminal_input
    import terminal_input_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    terminal_input_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          sel;
    logic [3:0]    offs;
    logic          wr_ctrl;
    logic          pop;
    logic          flush;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic [7:0]    count8;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          irq_en;
    logic [31:0]   status;
    logic          unused_bits;

    assign sel     = (bus.addr[31:8] == TERMIN_BASE);
    assign offs    = bus.addr[3:0];
    assign wr_ctrl = bus.we && sel && (offs == OFFS_CONTROL);
    assign flush   = wr_ctrl && bus.data_write[CTRL_FLUSH];
    // A store wins over a coincident load, so a pop needs we low.
    assign pop     = bus.re && !bus.we && sel && (offs == OFFS_DATA);
    assign count8  = 8'(count);

    assign bus.key_ready = !full;
    assign bus.irq       = irq_en && !empty;
    assign unused_bits   = ^{bus.data_write[31:3], bus.addr[7:4]};

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.key_valid),
        .pop     (pop),
        .flush   (flush),
        .din     (bus.key_data),
        .dout    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // A byte dropped on the same edge as a clear still leaves overflow set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (bus.key_valid && full) begin
                overflow <= 1'b1;
            end else if (wr_ctrl && bus.data_write[CTRL_CLR_OVF]) begin
                overflow <= 1'b0;
            end
            if (wr_ctrl) begin
                irq_en <= bus.data_write[CTRL_IRQ_EN];
            end
        end
    end

    always_comb begin
        status                       = '0;
        status[STAT_EMPTY]           = empty;
        status[STAT_FULL]            = full;
        status[STAT_OVERFLOW]        = overflow;
        status[STAT_IRQ_EN]          = irq_en;
        status[STAT_COUNT_LSB +: 8]  = count8;
    end

    always_comb begin
        bus.data_read = 32'h0;
        if (sel) begin
            case (offs)
                OFFS_DATA:    bus.data_read = empty ? EMPTY_READ : {24'h0, head};
                OFFS_STATUS:  bus.data_read = status;
                OFFS_CONTROL: bus.data_read = {29'h0, irq_en, 2'b00};
                default:      bus.data_read = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_terminal_input.sv
// tb/tb_terminal_input.sv - directed self-checking bench for terminal_input
module tb_terminal_input;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    terminal_input_if bus ();

    terminal_input #(.DEPTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each cycle task starts 1 ns after a rising edge and ends 1 ns after the next.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.we         = 1'b0;
        bus.re         = 1'b0;
        bus.addr       = 32'h0;
        bus.data_write = 32'h0;
        bus.key_valid  = 1'b0;
        bus.key_data   = 8'h0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.key_valid = 1'b1;
        bus.key_data  = b;
        step();
        bus.key_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.re   = 1'b1;
        #4;
        d = bus.data_read;
        step();
        bus.re = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #2;
        d = bus.data_read;
    endtask

    task automatic write_ctrl(input logic [31:0] v);
        bus.addr       = 32'h0000_0108;
        bus.data_write = v;
        bus.we         = 1'b1;
        step();
        bus.we         = 1'b0;
        bus.data_write = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus_idle();
        reset_n = 1'b0;
        #2;
        checks++;
        if (bus.key_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_key_ready got=%b exp=1", bus.key_ready);
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", bus.irq);
        end
        peek(32'h0000_0200, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_unselected got=%h exp=00000000", d);
        end
        peek(32'h0000_0104, d);
        checks++;
        if (d !== 32'h0000_0001) begin
            failures++;
            $display("FAIL reset_status got=%h exp=00000001", d);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [7:0]  exp_b [3];
        exp_b = '{8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 3; i++) push_byte(exp_b[i]);
        load(32'h0000_0104, d);
        checks++;
        if (d !== 32'h0000_0300) begin
            failures++;
            $display("FAIL basic_status3 got=%h exp=00000300", d);
        end
        for (int i = 0; i < 3; i++) begin
            load(32'h0000_0100, d);
            checks++;
            if (d !== {24'h0, exp_b[i]}) begin
                failures++;
                $display("FAIL basic_data%0d got=%h exp=%h", i, d, {24'h0, exp_b[i]});
            end
        end
        load(32'h0000_0104, d);
        checks++;
        if (d !== 32'h0000_0001) begin
            failures++;
            $display("FAIL basic_status_empty got=%h exp=00000001", d);
        end
    endtask

    task automatic test_full_overflow();
        logic [31:0] d;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        checks++;
        if (bus.key_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_key_ready got=%b exp=0", bus.key_ready);
        end
        peek(32'h0000_0104, d);
        checks++;
        if (d !== 32'h0000_1002) begin
            failures++;
            $display("FAIL full_status got=%h exp=00001002", d);
        end
        push_byte(8'hAA);
        peek(32'h0000_0104, d);
        checks++;
        if (d !== 32'h0000_1006) begin
            failures++;
            $display("FAIL overflow_status got=%h exp=00001006", d);
        end
        for (int i = 0; i < 16; i++) begin
            load(32'h0000_0100, d);
            checks++;
            if (d !== 32'(i)) begin
                failures++;
                $display("FAIL drain%0d got=%h exp=%h", i, d, 32'(i));
            end
        end
        peek(32'h0000_0100, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL drained_data got=%h exp=ffffffff", d);
        end
        peek(32'h0000_0104, d);
        checks++;
        if (d !== 32'h0000_0005) begin
            failures++;
            $display("FAIL drained_status got=%h exp=00000005", d);
        end
        write_ctrl(32'h2);
        peek(32'h0000_0104, d);
        checks++;
        if (d !== 32'h0000_0001) begin
            failures++;
            $display("FAIL clr_overflow got=%h exp=00000001", d);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        push_byte(8'h33);
        bus.key_valid = 1'b1;
        bus.key_data  = 8'h55;
        load(32'h0000_0100, d);
        bus.key_valid = 1'b0;
        checks++;
        if (d !== 32'h0000_0033) begin
            failures++;
            $display("FAIL simul_old_byte got=%h exp=00000033", d);
        end
        peek(32'h0000_0104, d);
        checks++;
        if (d !== 32'h0000_0100) begin
            failures++;
            $display("FAIL simul_count got=%h exp=00000100", d);
        end
        load(32'h0000_0100, d);
        checks++;
        if (d !== 32'h0000_0055) begin
            failures++;
            $display("FAIL simul_new_byte got=%h exp=00000055", d);
        end
        // Store and load together: store wins, nothing is popped.
        push_byte(8'h66);
        bus.we = 1'b1;
        bus.data_write = 32'h0;
        load(32'h0000_0100, d);
        bus.we = 1'b0;
        load(32'h0000_0100, d);
        checks++;
        if (d !== 32'h0000_0066) begin
            failures++;
            $display("FAIL we_re_no_pop got=%h exp=00000066", d);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        write_ctrl(32'h4);
        peek(32'h0000_0108, d);
        checks++;
        if (d !== 32'h0000_0004) begin
            failures++;
            $display("FAIL ctrl_read got=%h exp=00000004", d);
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_empty got=%b exp=0", bus.irq);
        end
        bus.key_valid = 1'b1;
        bus.key_data  = 8'h10;
        #4;
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_before_edge got=%b exp=0", bus.irq);
        end
        step();
        bus.key_valid = 1'b0;
        checks++;
        if (bus.irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_rise got=%b exp=1", bus.irq);
        end
        peek(32'h0000_0104, d);
        checks++;
        if (d !== 32'h0000_0108) begin
            failures++;
            $display("FAIL irq_status got=%h exp=00000108", d);
        end
        load(32'h0000_0100, d);
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_fall got=%b exp=0", bus.irq);
        end
        push_byte(8'h11);
        write_ctrl(32'h0);
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_disabled got=%b exp=0", bus.irq);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) push_byte(8'(8'h20 + i));
        peek(32'h0000_0104, d);
        checks++;
        if (d !== 32'h0000_0500) begin
            failures++;
            $display("FAIL flush_pre_count got=%h exp=00000500", d);
        end
        bus.key_valid = 1'b1;
        bus.key_data  = 8'h77;
        write_ctrl(32'h1);
        bus.key_valid = 1'b0;
        peek(32'h0000_0104, d);
        checks++;
        if (d !== 32'h0000_0001) begin
            failures++;
            $display("FAIL flush_status got=%h exp=00000001", d);
        end
        peek(32'h0000_0100, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL flush_data got=%h exp=ffffffff", d);
        end
        push_byte(8'h78);
        load(32'h0000_0100, d);
        checks++;
        if (d !== 32'h0000_0078) begin
            failures++;
            $display("FAIL flush_next got=%h exp=00000078", d);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) push_byte(8'(8'h80 + i));
        bus.addr = 32'h0000_0104;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.data_read !== 32'h0000_0001) begin
            failures++;
            $display("FAIL areset_status got=%h exp=00000001", bus.data_read);
        end
        checks++;
        if (bus.key_ready !== 1'b1) begin
            failures++;
            $display("FAIL areset_key_ready got=%b exp=1", bus.key_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        push_byte(8'h99);
        load(32'h0000_0200, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL unselected_load got=%h exp=00000000", d);
        end
        load(32'h0000_0100, d);
        checks++;
        if (d !== 32'h0000_0099) begin
            failures++;
            $display("FAIL unselected_no_pop got=%h exp=00000099", d);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_full_overflow();
        test_simultaneous();
        test_irq();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/terminal_input.md
# terminal_input

Memory-mapped terminal input device, the receive-side counterpart of the terminal output port on the CPU data bus. It accepts bytes from an external source (keyboard/host link) over a valid/ready handshake and buffers them in a FIFO. The CPU drains them with loads from the data register and polls or takes an interrupt on the status register. The block sits on the same data-memory bus as the other peripherals, decoded at 0x0000_0100–0x0000_01FF.

## Interface
- DEPTH, 16: FIFO depth in bytes; power of two, 2..256.
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  1  CPU store strobe.
- re  in  1  CPU load strobe; a pop occurs only when re is high.
- addr  in  32  CPU byte address; block selected when addr[31:8] == 24'h000001.
- data_write  in  32  store data.
- data_read  out  32  load data, combinational from addr and state.
- key_data  in  8  incoming byte.
- key_valid  in  1  source offers key_data.
- key_ready  out  1  block can accept; equals !full.
- irq  out  1  level interrupt: irq_en && !empty.

## Operation
- Register offsets are decoded on addr[3:0] within the selected window. Other offsets read 32'h0 and ignore writes.
  - 0x0 DATA (R): {24'h0, head byte}. Reads 32'hFFFF_FFFF when empty. A load (re && selected && offset 0x0 && !empty) pops one byte.
  - 0x4 STATUS (R): {16'h0, count[7:0], 4'h0, irq_en, overflow, full, empty}. count is zero-extended to 8 bits. Reading STATUS has no side effects.
  - 0x8 CONTROL (W): bit0 = flush FIFO; bit1 = clear overflow; bit2 = irq_en value (stored). Reads return {29'h0, irq_en, 2'b00}.
- When not selected, data_read = 32'h0.
- Push: key_valid && key_ready at a clock edge stores key_data at the tail.
- overflow is a sticky bit. It is set on any edge with key_valid && full; that byte is not stored. It is cleared only by a CONTROL write with bit1 = 1, or by reset.
- Simultaneous push and pop: both are performed and count is unchanged. This is legal in every non-full state. When full, no push can occur because key_ready is low.
- Pop when empty: no state change.
- A flush (CONTROL bit0) has priority over a same-cycle push or pop. Count goes to 0, pointers go to 0, and the pushed byte is discarded. Overflow is unaffected unless bit1 is also set.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits internally. full is count == DEPTH; empty is count == 0.

## Timing
- Reset values (asynchronous assert): count = 0, pointers = 0, overflow = 0, irq_en = 0. Resulting outputs: key_ready = 1, irq = 0, data_read = 32'h0 for an unselected address.
- Reset asserted mid-operation discards FIFO contents immediately. Storage RAM need not be cleared.
- Push-to-visibility latency: a byte accepted at edge N appears at DATA, and in STATUS.count, combinationally after edge N. A load issued in cycle N+1 returns it.
- Pop takes effect at the edge ending the load cycle. The next load sees the next byte.
- key_ready and irq change only after clock edges. They never depend combinationally on key_valid or the CPU bus.
- A store and a load never coincide in the same cycle. If we and re are both high, the store is processed and no pop occurs.

## Structure
- The shared peripheral package holds:
  - TERMIN_BASE = 24'h000001
  - offsets DATA = 4'h0, STATUS = 4'h4, CONTROL = 4'h8
  - STATUS bit positions
  - EMPTY_READ = 32'hFFFF_FFFF, also used by the terminal output port's read value
- One sub-module: byte_fifo (parameter DEPTH; push, pop, flush, din, dout, count, full, empty). The top level holds address decode, the control/overflow registers, and read muxing.

## Test plan
- Reset, then push 0x41, 0x42, 0x43. STATUS reads 0x0000_0300 (count 3). DATA load sequence returns 0x41, 0x42, 0x43. STATUS then reads 0x0000_0001 (empty).
- Push 16 bytes 0x00..0x0F: key_ready = 0 and STATUS bit1 (full) = 1. Hold key_valid with 0xAA for one cycle: overflow = 1 and 0xAA is not stored. Drain: returns 0x00..0x0F. Write CONTROL = 0x2: overflow = 0.
- With 1 byte queued, push 0x55 and load DATA in the same cycle. Load returns the old byte, count stays 1, next load returns 0x55.
- Write CONTROL = 0x4, push 0x10: irq rises the cycle after acceptance. Pop: irq falls after that edge. Write CONTROL = 0x0 with data queued: irq = 0.
- Queue 5 bytes, then write CONTROL = 0x1 while pushing 0x77. count = 0, DATA reads 0xFFFF_FFFF, and 0x77 is absent.
- Deassert reset_n asynchronously mid-stream with 8 bytes queued. STATUS = 0x0000_0001 and key_ready = 1 immediately. Load at addr 0x0000_0200 returns 0x0 with no pop.
